// File: rtl/doppler_pkg.sv
// doppler_pkg: shared FSM states, default constants and width helpers for the Doppler estimator
package doppler_pkg;
   typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;
   localparam int SPEED_OF_SOUND_DEF = 343;
   function automatic int sos_w(input int sos);
      return $clog2(sos + 1);
   endfunction
   function automatic int num_w(input int freq_w, input int sos, input int frac);
      return freq_w + sos_w(sos) + frac;
   endfunction
endpackage

// File: rtl/restoring_divider.sv
// restoring_divider: one quotient bit per cycle; first bit is resolved on the start edge so done lands W cycles after start
module restoring_divider #(
   parameter int W  = 45,
   parameter int DW = 32
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          start,
   input  logic [W-1:0]  dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  quotient
);
   localparam int CW = $clog2(W + 1);
   logic [DW-1:0] den, rem, r_in, d_in, rem_n;
   logic [W-1:0] q_in, quo_n;
   logic [DW:0] sh;
   logic ge;
   logic [CW-1:0] cnt;
   always_comb begin
      r_in  = start ? '0 : rem;
      q_in  = start ? dividend : quotient;
      d_in  = start ? divisor : den;
      sh    = {r_in, q_in[W-1]};
      ge    = sh >= {1'b0, d_in};
      rem_n = ge ? DW'(sh - {1'b0, d_in}) : sh[DW-1:0];
      quo_n = {q_in[W-2:0], ge};
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         den      <= '0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            den      <= divisor;
            rem      <= rem_n;
            quotient <= quo_n;
            busy     <= 1'b1;
            cnt      <= CW'(W - 1);
         end else if (busy) begin
            rem      <= rem_n;
            quotient <= quo_n;
            cnt      <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/doppler_velocity_estimator.sv
// doppler_velocity_estimator: peak frequency to saturated signed radial velocity with band rejection and running average
module doppler_velocity_estimator
   import doppler_pkg::*;
#(
   parameter int EMITTED_FREQUENCY = 40000,
   parameter int SPEED_OF_SOUND    = SPEED_OF_SOUND_DEF,
   parameter int FREQ_W            = 32,
   parameter int FRAC_BITS         = 4,
   parameter int VEL_W             = 16,
   parameter int MAX_SHIFT_HZ      = 4000,
   parameter int AVG_LOG2          = 2
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    peak_valid_in,
   input  logic [FREQ_W-1:0]       peak_freq_in,
   output logic                    ready_out,
   output logic                    velocity_valid_out,
   output logic signed [VEL_W-1:0] velocity_out,
   output logic                    towards_out,
   output logic                    saturated_out,
   output logic                    avg_valid_out,
   output logic signed [VEL_W-1:0] avg_velocity_out,
   output logic                    out_of_band_out,
   output logic                    drop_out
);
   localparam int NUM_W = num_w(FREQ_W, SPEED_OF_SOUND, FRAC_BITS);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = VEL_W + AVG_LOG2;
   localparam logic [FREQ_W-1:0] EF = FREQ_W'(EMITTED_FREQUENCY);
   localparam logic [FREQ_W-1:0] MAXS = FREQ_W'(MAX_SHIFT_HZ);
   localparam logic [NUM_W-1:0] VMAX = {{(NUM_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
   localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2+1)'(DEPTH);
   state_t state;
   logic [FREQ_W-1:0] peak, delta;
   logic [NUM_W-1:0] num, quo;
   logic start, done, busy, above, below, in_band, sat;
   logic [VEL_W-1:0] mag;
   logic signed [VEL_W-1:0] buffer [DEPTH];
   logic [AVG_LOG2-1:0] wptr;
   logic [AVG_LOG2:0] fill;
   logic signed [SUM_W-1:0] sum, sum_n;
   always_comb begin
      above   = peak > EF;
      below   = peak < EF;
      delta   = above ? peak - EF : EF - peak;
      num     = (NUM_W'(delta) * NUM_W'(SPEED_OF_SOUND)) << FRAC_BITS;
      in_band = delta <= MAXS && peak != '0;
      start   = state == PREP && in_band;
      sat     = quo > VMAX;
      mag     = sat ? VMAX[VEL_W-1:0] : quo[VEL_W-1:0];
      sum_n   = sum + SUM_W'(velocity_out) - SUM_W'(buffer[wptr]);
   end
   restoring_divider #(.W(NUM_W), .DW(FREQ_W)) u_div (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .start    (start),
      .dividend (num),
      .divisor  (peak),
      .busy     (busy),
      .done     (done),
      .quotient (quo)
   );
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state              <= IDLE;
         peak               <= '0;
         ready_out          <= 1'b1;
         velocity_valid_out <= 1'b0;
         velocity_out       <= '0;
         towards_out        <= 1'b0;
         saturated_out      <= 1'b0;
         out_of_band_out    <= 1'b0;
         drop_out           <= 1'b0;
      end else begin
         velocity_valid_out <= 1'b0;
         out_of_band_out    <= 1'b0;
         drop_out           <= peak_valid_in && state != IDLE;
         case (state)
            IDLE: if (peak_valid_in) begin
               peak      <= peak_freq_in;
               state     <= PREP;
               ready_out <= 1'b0;
            end
            PREP: if (in_band) state <= DIV;
            else begin
               out_of_band_out <= 1'b1;
               state           <= IDLE;
               ready_out       <= 1'b1;
            end
            DIV: if (done && !busy) begin
               velocity_out       <= below ? -mag : mag;
               towards_out        <= above;
               saturated_out      <= sat;
               velocity_valid_out <= 1'b1;
               state              <= OUT;
            end
            OUT: begin
               state     <= IDLE;
               ready_out <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
         wptr             <= '0;
         fill             <= '0;
         sum              <= '0;
         avg_valid_out    <= 1'b0;
         avg_velocity_out <= '0;
      end else begin
         avg_valid_out <= 1'b0;
         if (velocity_valid_out) begin
            buffer[wptr]     <= velocity_out;
            wptr             <= wptr + 1'b1;
            sum              <= sum_n;
            fill             <= fill == FULL ? fill : fill + 1'b1;
            avg_valid_out    <= fill >= FULL - 1'b1;
            avg_velocity_out <= VEL_W'(sum_n >>> AVG_LOG2);
         end
      end
   end
endmodule

// File: tb/tb_doppler_velocity_estimator.sv
// tb_doppler_velocity_estimator: table-driven directed vectors on a 16-bit and an 8-bit velocity instance
module tb_doppler_velocity_estimator;
   logic clk = 1'b0, rst = 1'b1, pv = 1'b0;
   logic [31:0] pf = '0;
   logic r16, vv16, t16, s16, av16, o16, d16;
   logic signed [15:0] v16, a16;
   logic r8, vv8, t8, s8, av8, o8, d8;
   logic signed [7:0] v8, a8;
   int total = 0, bad = 0;
   typedef struct {
      logic [31:0] f;
      bit oob;
      int drop_at;
      int v16;
      bit t;
      bit s16;
      int v8;
      bit s8;
      bit avv;
      int a16;
      int a8;
   } vec_t;
   vec_t tbl[16];
   always #5 clk = ~clk;
   doppler_velocity_estimator u16 (
      .clk_in(clk), .rst_in(rst), .peak_valid_in(pv), .peak_freq_in(pf),
      .ready_out(r16), .velocity_valid_out(vv16), .velocity_out(v16), .towards_out(t16),
      .saturated_out(s16), .avg_valid_out(av16), .avg_velocity_out(a16),
      .out_of_band_out(o16), .drop_out(d16)
   );
   doppler_velocity_estimator #(.VEL_W(8)) u8 (
      .clk_in(clk), .rst_in(rst), .peak_valid_in(pv), .peak_freq_in(pf),
      .ready_out(r8), .velocity_valid_out(vv8), .velocity_out(v8), .towards_out(t8),
      .saturated_out(s8), .avg_valid_out(av8), .avg_velocity_out(a8),
      .out_of_band_out(o8), .drop_out(d8)
   );
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask
   task automatic run(input int idx, input vec_t e);
      int nv = 0, nv8 = 0, no = 0, na = 0, nd = 0, rdy = 0;
      int v16c = 0, v8c = 0, tc = 0, s16c = 0, s8c = 0, a16c = 0, a8c = 0;
      string p = $sformatf("row%0d_", idx);
      @(negedge clk);
      chk({p, "ready"}, int'(r16), 1);
      pf = e.f;
      pv = 1'b1;
      for (int n = 1; n <= 55; n++) begin
         @(negedge clk);
         if (vv16 && nv == 0) begin nv = n; v16c = int'(v16); tc = int'(t16); s16c = int'(s16); end
         if (vv8 && nv8 == 0) begin nv8 = n; v8c = int'(v8); s8c = int'(s8); end
         if (o16 && no == 0) no = n;
         if (av16 && na == 0) begin na = n; a16c = int'(a16); a8c = int'(a8); end
         if (d16 && nd == 0) nd = n;
         if (nv != 0 && n == nv + 1) rdy = int'(r16);
         pv = (n == e.drop_at);
         if (pv) pf = 32'd39657;
      end
      pv = 1'b0;
      chk({p, "drop_cycle"}, nd, e.drop_at != 0 ? e.drop_at + 1 : 0);
      if (e.oob) begin
         chk({p, "oob_cycle"}, no, 2);
         chk({p, "oob_no_valid"}, nv, 0);
      end else begin
         chk({p, "valid_cycle16"}, nv, 47);
         chk({p, "valid_cycle8"}, nv8, 47);
         chk({p, "no_oob"}, no, 0);
         chk({p, "vel16"}, v16c, e.v16);
         chk({p, "towards"}, tc, int'(e.t));
         chk({p, "sat16"}, s16c, int'(e.s16));
         chk({p, "vel8"}, v8c, e.v8);
         chk({p, "sat8"}, s8c, int'(e.s8));
         chk({p, "ready_after"}, rdy, 1);
         chk({p, "avg_cycle"}, na, e.avv ? 48 : 0);
         if (e.avv) begin
            chk({p, "avg16"}, a16c, e.a16);
            chk({p, "avg8"}, a8c, e.a8);
         end
      end
   endtask
   initial begin
      int seen;
      tbl[0]  = '{32'd40343, 1'b0, 0, 46, 1'b1, 1'b0, 46, 1'b0, 1'b0, 0, 0};
      tbl[1]  = '{32'd39657, 1'b0, 0, -47, 1'b0, 1'b0, -47, 1'b0, 1'b0, 0, 0};
      tbl[2]  = '{32'd40000, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0};
      tbl[3]  = '{32'd45000, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0};
      tbl[4]  = '{32'd0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0};
      tbl[5]  = '{32'd41000, 1'b0, 0, 133, 1'b1, 1'b0, 127, 1'b1, 1'b1, 33, 31};
      tbl[6]  = '{32'd38000, 1'b0, 0, -288, 1'b0, 1'b0, -127, 1'b1, 1'b1, -51, -12};
      tbl[7]  = '{32'd40343, 1'b0, 0, 46, 1'b1, 1'b0, 46, 1'b0, 1'b1, -28, 11};
      tbl[8]  = '{32'd44000, 1'b0, 0, 498, 1'b1, 1'b0, 127, 1'b1, 1'b1, 97, 43};
      tbl[9]  = '{32'd44001, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0};
      tbl[10] = '{32'd40343, 1'b0, 5, 46, 1'b1, 1'b0, 46, 1'b0, 1'b1, 75, 23};
      tbl[11] = '{32'd40343, 1'b0, 0, 46, 1'b1, 1'b0, 46, 1'b0, 1'b0, 0, 0};
      tbl[12] = '{32'd40343, 1'b0, 0, 46, 1'b1, 1'b0, 46, 1'b0, 1'b0, 0, 0};
      tbl[13] = '{32'd39657, 1'b0, 0, -47, 1'b0, 1'b0, -47, 1'b0, 1'b0, 0, 0};
      tbl[14] = '{32'd39657, 1'b0, 0, -47, 1'b0, 1'b0, -47, 1'b0, 1'b1, -1, -1};
      tbl[15] = '{32'd40343, 1'b0, 0, 46, 1'b1, 1'b0, 46, 1'b0, 1'b1, -1, -1};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", int'(r16), 1);
      chk("rst_ready8", int'(r8), 1);
      chk("rst_valid", int'(vv16), 0);
      chk("rst_vel", int'(v16), 0);
      chk("rst_towards", int'(t16), 0);
      chk("rst_sat", int'(s16), 0);
      chk("rst_avg_valid", int'(av16), 0);
      chk("rst_avg", int'(a16), 0);
      chk("rst_oob", int'(o16), 0);
      chk("rst_drop", int'(d16), 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 11) begin
            @(negedge clk);
            pf = 32'd40343;
            pv = 1'b1;
            @(negedge clk);
            pv = 1'b0;
            repeat (20) @(negedge clk);
            chk("mid_div_busy", int'(r16), 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("mid_div_ready", int'(r16), 1);
            seen = 0;
            repeat (60) begin
               @(negedge clk);
               if (vv16 || av16 || vv8) seen = 1;
            end
            chk("mid_div_no_pulse", seen, 0);
         end
         run(i, tbl[i]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
